// File: rtl/fir_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fir_pkg : shared widths and constants for the FIR output stage.  Rev 1.0
// ---------------------------------------------------------------------------
package fir_pkg;

  localparam int FIR_W     = 16;
  localparam int OUT_W_DEF = 8;

  // Accumulator sized so DECIM full-scale samples can never wrap.
  function automatic int acc_width(input int log2_decim);
    return FIR_W + log2_decim;
  endfunction

  function automatic int round_const(input int shift);
    return 1 << (shift - 1);
  endfunction

  function automatic int sat_max(input int width);
    return (1 << width) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_out_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fir_out_fifo : synchronous FIFO, sync active-low reset, show-ahead head.  Rev 1.0
// ---------------------------------------------------------------------------
module fir_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot at this edge, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      level <= level + LVL_W'(1);
      else if (do_pop && !do_push) level <= level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/fir_decim_out.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fir_decim_out : integrate-and-dump decimator, round/saturate, output FIFO.  Rev 1.0
// ---------------------------------------------------------------------------
module fir_decim_out
  import fir_pkg::*;
#(
  parameter int DECIM      = 4,
  parameter int LOG2_DECIM = 2,
  parameter int FRAC_SHIFT = 5,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [FIR_W-1:0]              din,
  input  logic                          din_valid,
  output logic [OUT_W-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          sat,
  output logic                          ovf,
  input  logic                          ovf_clr
);

  localparam int ACC_W = acc_width(LOG2_DECIM);
  localparam int SHIFT = LOG2_DECIM + FRAC_SHIFT;
  // One spare bit so adding the rounding constant to a full-scale sum cannot wrap.
  localparam int RND_W = ACC_W + 1;
  localparam logic [RND_W-1:0] RND_ADD = RND_W'(round_const(SHIFT));
  localparam logic [RND_W-1:0] SAT_LIM = RND_W'(sat_max(OUT_W));

  logic [LOG2_DECIM-1:0] cnt;
  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      sum;
  logic [RND_W-1:0]      rounded;
  logic [OUT_W-1:0]      result;
  logic [OUT_W-1:0]      head;
  logic                  over;
  logic                  dump;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic                  drop;

  always_comb begin
    sum     = acc + ACC_W'(din);
    rounded = (RND_W'(sum) + RND_ADD) >> SHIFT;
    over    = (rounded > SAT_LIM);
    result  = over ? OUT_W'(SAT_LIM) : OUT_W'(rounded);
  end

  assign dump      = din_valid && (cnt == LOG2_DECIM'(DECIM - 1));
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? head : '0;
  assign drop      = dump && full && !pop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
      acc <= '0;
      sat <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (din_valid) begin
        cnt <= cnt + LOG2_DECIM'(1);
        acc <= (cnt == '0) ? ACC_W'(din) : sum;
      end
      sat <= dump && over;
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  fir_out_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (dump),
    .wdata (result),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

endmodule
`default_nettype wire

// File: tb/tb_fir_decim_out.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fir_decim_out : vector table + per-cycle scoreboard for fir_decim_out.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_fir_decim_out;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] din;
  logic        din_valid;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fifo_level;
  logic        sat;
  logic        ovf;
  logic        ovf_clr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fir_decim_out dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .sat        (sat),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one input cycle; returns just after the edge that consumed it.
  task automatic cyc(input logic [15:0] d, input logic v);
    din       = d;
    din_valid = v;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: q holds expected FIFO contents, built from the driven stimulus.
  int q[$];
  int m_cnt   = 0;
  int m_acc   = 0;
  bit m_ovf   = 0;
  bit m_sat   = 0;
  bit started = 0;

  always @(negedge clk) begin
    int  s;
    int  r;
    bit  pop_m;
    bit  push_m;
    if (started) begin
      chk("sb_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("sb_data", 32'(out_data), (q.size() > 0) ? q[0] : 0);
      chk("sb_level", 32'(fifo_level), 32'(q.size()));
      chk("sb_sat", 32'(sat), 32'(m_sat));
      chk("sb_ovf", 32'(ovf), 32'(m_ovf));
    end
    if (!reset) begin
      q.delete();
      m_cnt   = 0;
      m_acc   = 0;
      m_ovf   = 0;
      m_sat   = 0;
      started = 1;
    end else if (started) begin
      pop_m  = out_ready && (q.size() > 0);
      push_m = 0;
      m_sat  = 0;
      r      = 0;
      if (din_valid) begin
        s = ((m_cnt == 0) ? 0 : m_acc) + int'(din);
        if (m_cnt == 3) begin
          r = (s + 64) >> 7;
          if (r > 255) begin
            r     = 255;
            m_sat = 1;
          end
          push_m = 1;
        end
        m_acc = s;
        m_cnt = (m_cnt + 1) % 4;
      end
      if (pop_m) void'(q.pop_front());
      if (push_m && q.size() >= 4) m_ovf = 1;
      else begin
        if (push_m) q.push_back(r);
        if (ovf_clr) m_ovf = 0;
      end
    end
  end

  typedef struct {
    string       name;
    logic [15:0] d;
    logic [7:0]  exp_out;
    logic        exp_sat;
  } vec_t;

  vec_t tbl[5];
  int   nres;

  initial begin
    tbl[0] = '{"steady_260", 16'd260,   8'd8,   1'b0};
    tbl[1] = '{"round_up_16", 16'd16,   8'd1,   1'b0};
    tbl[2] = '{"round_dn_15", 16'd15,   8'd0,   1'b0};
    tbl[3] = '{"fir_max",    16'd6630,  8'd207, 1'b0};
    tbl[4] = '{"saturate",   16'd65535, 8'd255, 1'b1};

    reset = 1'b0; din = '0; din_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_sat", 32'(sat), 0);
    chk("rst_ovf", 32'(ovf), 0);
    reset = 1'b1;
    cyc(16'd999, 1'b0);

    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 4; k++) cyc(tbl[i].d, 1'b1);
      chk({tbl[i].name, "_valid"}, 32'(out_valid), 1);
      chk({tbl[i].name, "_data"}, 32'(out_data), 32'(tbl[i].exp_out));
      chk({tbl[i].name, "_sat"}, 32'(sat), 32'(tbl[i].exp_sat));
      cyc(16'd999, 1'b0);
      chk({tbl[i].name, "_one_cycle"}, 32'(out_valid), 0);
    end

    // Backpressure: five results into a four-deep FIFO.
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) cyc(16'd128, 1'b1);
    chk("bp_level", 32'(fifo_level), 4);
    chk("bp_ovf", 32'(ovf), 1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_pop_valid", 32'(out_valid), 1);
      chk("bp_pop_data", 32'(out_data), 4);
      cyc(16'd999, 1'b0);
    end
    chk("bp_drained_valid", 32'(out_valid), 0);
    chk("bp_drained_data", 32'(out_data), 0);
    ovf_clr = 1'b1;
    cyc(16'd999, 1'b0);
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(ovf), 0);

    // Gapped input: one result every 8 cycles, invalid samples ignored.
    nres = 0;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) cyc(16'd256, 1'b1);
      else            cyc(16'd999, 1'b0);
      if (out_valid) begin
        nres++;
        chk("gap_data", 32'(out_data), 8);
      end
    end
    chk("gap_count", 32'(nres), 2);

    // Full FIFO with push and pop on the same edge.
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) cyc(16'd128, 1'b1);
    for (int k = 0; k < 3; k++) cyc(16'd256, 1'b1);
    out_ready = 1'b1;
    cyc(16'd256, 1'b1);
    out_ready = 1'b0;
    chk("simul_level", 32'(fifo_level), 4);
    chk("simul_ovf", 32'(ovf), 0);
    out_ready = 1'b1;
    repeat (5) cyc(16'd999, 1'b0);
    chk("simul_drained", 32'(out_valid), 0);

    // Reset discards a partial accumulation.
    cyc(16'd1000, 1'b1);
    cyc(16'd1000, 1'b1);
    reset = 1'b0;
    cyc(16'd1000, 1'b1);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) cyc(16'd16, 1'b1);
    chk("rst_mid_valid", 32'(out_valid), 1);
    chk("rst_mid_data", 32'(out_data), 1);
    cyc(16'd999, 1'b0);
    chk("rst_mid_single", 32'(out_valid), 0);

    // Reset with a full FIFO.
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) cyc(16'd128, 1'b1);
    chk("rst_full_pre", 32'(fifo_level), 4);
    reset = 1'b0;
    cyc(16'd999, 1'b0);
    chk("rst_full_valid", 32'(out_valid), 0);
    chk("rst_full_level", 32'(fifo_level), 0);
    reset = 1'b1;
    cyc(16'd999, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_decim_out.md
Name: fir_decim_out

Overview:
- Downstream stage of the 4-tap FIR. Consumes the FIR's 16-bit output stream.
- Performs integrate-and-dump decimation by DECIM, rounding and saturation to OUT_W bits.
- Buffers results in a small FIFO behind a valid/ready handshake.
- Reports saturation events and FIFO overflow to the consumer.

Parameters:
- DECIM, 4: decimation ratio. Power of two, legal range 2..16.
- LOG2_DECIM, 2: log2(DECIM). Must match DECIM.
- FRAC_SHIFT, 5: extra right shift applied after averaging (FIR gain removal).
- OUT_W, 8: output sample width.
- FIFO_DEPTH, 4: output FIFO entries. Power of two.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- din  in  16  FIR output sample, unsigned.
- din_valid  in  1  din is valid this cycle. Tie high for free-running FIR.
- out_data  out  OUT_W  FIFO head sample. Forced 0 when out_valid=0.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head when out_valid&out_ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- sat  out  1  one-cycle pulse: the result pushed at this edge was saturated.
- ovf  out  1  sticky: a result was dropped because the FIFO was full.
- ovf_clr  in  1  clears ovf.

Behaviour:
- Reset (reset=0 at a clk edge):
  - cnt=0, acc=0, FIFO emptied.
  - out_valid=0, out_data=0, fifo_level=0, sat=0, ovf=0.
  - Reset overrides all other inputs, including during a partial accumulation.
- Accumulator:
  - acc width is 16+LOG2_DECIM, so it never overflows.
  - On din_valid with cnt==0: acc<=din. On din_valid with cnt!=0: acc<=acc+din.
  - cnt increments modulo DECIM on each valid sample.
  - din_valid=0: acc and cnt hold.
- Dump, on the edge accepting the DECIM-th sample (cnt==DECIM-1 & din_valid):
  - S = acc+din, computed combinationally.
  - Total shift T = LOG2_DECIM+FRAC_SHIFT.
  - R = (S + 2^(T-1)) >> T, i.e. round half up.
  - If R > 2^OUT_W-1, then R = 2^OUT_W-1 and sat pulses high for the cycle after the edge.
  - R is pushed into the FIFO at that same edge. out_valid rises the next cycle, so latency is 1 cycle from the last sample.
- FIFO:
  - In-order delivery.
  - Pop when out_valid&out_ready.
  - Push and pop at the same edge are legal in any state. Full + push + pop means no drop and level unchanged.
  - Push while full with no pop: the new result is discarded, stored data is unchanged, and ovf<=1.
  - Pop while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level updates at the edge.
- ovf:
  - Set by a drop. Cleared by ovf_clr.
  - Drop and ovf_clr at the same edge: set wins.
- sat is asserted even if the saturated result is dropped. ovf also sets in that case.

Decomposition:
- Shared package fir_pkg:
  - FIR data width (16) and OUT_W default.
  - Accumulator width function.
  - Rounding constant function 2^(T-1).
  - Saturation max constant.
- Sub-module fir_out_fifo: synchronous FIFO with push, pop, full, empty and level, using the same clk/reset convention.
- Decimator, round and saturate logic stays in the top module.

Test Plan (defaults: DECIM=4, FRAC_SHIFT=5, T=7, rounding add 64):
- Steady output: din=260 with din_valid=1 for 4 cycles, out_ready=1 -> sum 1040, out_data=8 with out_valid for 1 cycle starting the cycle after the 4th sample, sat=0.
- Rounding boundary: 4×16 -> out_data=1. 4×15 -> out_data=0. FIR max 4×6630 -> out_data=207, sat=0.
- Saturation: 4×65535 -> out_data=255 and a 1-cycle sat pulse.
- Backpressure and overflow:
  - out_ready=0, 20 samples of din=128 (5 results of 4).
  - Expect fifo_level=4, ovf=1 after the 5th dump.
  - Then out_ready=1: exactly 4 pops of value 4, then out_valid=0, out_data=0.
  - Then ovf_clr -> ovf=0.
- Gaps and simultaneity:
  - din_valid toggled 1010… with din=256 -> one result (value 8) per 8 cycles, with cnt holding during gaps.
  - With FIFO full, push and pop at the same edge -> no drop, ovf stays 0, level stays 4.
- Reset mid-operation:
  - 2 samples of 1000, then reset=0 for 1 cycle, then 4×16.
  - Expect a single result of 1; the pre-reset partial sum is discarded.
  - Reset asserted with a full FIFO -> out_valid=0 and level=0 the next cycle.
